// File: rtl/alu_pkg.sv
// alu_pkg: opcodes shared with the ALU, instruction layout and sequencer state encoding.
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3,
                           OP_XOR = 4'h4, OP_INC = 4'h5, OP_NOP = 4'hF;
    localparam int HALT_BIT = 21, OP_LSB = 17, ACC_BIT = 16, A_LSB = 8, B_LSB = 0;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_ISSUE = 3'd2,
                           S_WAIT = 3'd3, S_RETIRE = 3'd4, S_HALT = 3'd5;
    typedef struct packed {
        logic [3:0] op;
        logic       acc;
        logic [7:0] a;
        logic [7:0] b;
    } issue_t;
    typedef struct packed {
        logic   halt;
        issue_t body;
    } instr_t;
    localparam issue_t ISSUE_NOP = '{op: OP_NOP, acc: 1'b0, a: 8'h00, b: 8'h00};
    function automatic instr_t mk_instr(input logic h, input logic [3:0] op, input logic acc,
                                        input logic [7:0] a, input logic [7:0] b);
        logic [21:0] w;
        w = '0;
        w[HALT_BIT] = h;
        w[OP_LSB+:4] = op;
        w[ACC_BIT] = acc;
        w[A_LSB+:8] = a;
        w[B_LSB+:8] = b;
        return instr_t'(w);
    endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: operand/strobe bus between the sequencer and the ALU.
interface alu_sequencer_if;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic       alu_acc;
    logic       alu_en;
    logic       alu_done;
    logic [7:0] alu_results;
    modport master(output alu_a, alu_b, alu_op, alu_acc, alu_en, input alu_done, alu_results);
    modport slave(input alu_a, alu_b, alu_op, alu_acc, alu_en, output alu_done, alu_results);
endinterface

// File: rtl/instr_mem.sv
// instr_mem: DEPTH x 22 instruction store, synchronous write, combinational read, never reset.
module instr_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  instr_t                   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output instr_t                   rdata
);
    instr_t mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: steps through instruction memory, issuing each entry to an external
// multi-cycle ALU and retiring its result; a WAIT timeout halts with a sticky error.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  instr_t                   prog_data,
    input  logic                     start,
    alu_sequencer_if.master          alu,
    output logic [7:0]               result,
    output logic                     result_valid,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     busy,
    output logic                     halted,
    output logic                     error
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [2:0]    state;
    issue_t        ir;
    instr_t        rdata;
    logic [TW-1:0] tcnt;
    logic          done_q;
    logic          done_rise;
    logic          en;
    logic          can_prog;
    assign can_prog  = state == S_IDLE || state == S_HALT;
    // Only a fresh low-to-high transition completes; a level left over from the last op does not.
    assign done_rise = alu.alu_done & ~done_q;
    instr_mem #(.DEPTH(DEPTH)) u_mem (
        .clk  (clk),
        .we   (prog_we & can_prog),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr(pc),
        .rdata(rdata)
    );
    assign alu.alu_a   = ir.a;
    assign alu.alu_b   = ir.b;
    assign alu.alu_op  = ir.op;
    assign alu.alu_acc = ir.acc;
    assign alu.alu_en  = en;
    assign result_valid = state == S_RETIRE;
    assign halted       = state == S_HALT;
    assign busy         = !can_prog;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= ISSUE_NOP;
            en     <= 1'b0;
            result <= '0;
            error  <= 1'b0;
            tcnt   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= alu.alu_done;
            case (state)
                S_IDLE, S_HALT:
                    if (start) begin
                        state <= S_FETCH;
                        pc    <= '0;
                        error <= 1'b0;
                    end
                S_FETCH: begin
                    // The instruction register doubles as the operand hold for ISSUE and WAIT.
                    ir    <= rdata.body;
                    en    <= !rdata.halt;
                    state <= rdata.halt ? S_HALT : S_ISSUE;
                end
                S_ISSUE: begin
                    tcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT:
                    if (done_rise) begin
                        result <= alu.alu_results;
                        en     <= 1'b0;
                        state  <= S_RETIRE;
                    end else if (tcnt == TW'(TIMEOUT)) begin
                        error <= 1'b1;
                        en    <= 1'b0;
                        state <= S_HALT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                S_RETIRE:
                    if (pc == AW'(DEPTH - 1)) state <= S_HALT;
                    else begin
                        pc    <= pc + 1'b1;
                        state <= S_FETCH;
                    end
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed programs against a 4-cycle behavioural ALU with hang and
// sticky-done modes; expected results are hand-computed constants.
module tb_alu_sequencer;
    import alu_pkg::*;
    localparam int LAT = 4;
    logic        clk = 0;
    logic        rst = 1;
    logic        prog_we = 0;
    logic [3:0]  prog_addr = 0;
    logic [21:0] prog_data = 0;
    logic        start = 0;
    logic [7:0]  result;
    logic        result_valid;
    logic [3:0]  pc;
    logic        busy, halted, error;
    int          n_chk = 0, n_pass = 0;
    logic [7:0]  res_q [$];
    int          first_lat, halt_cyc;
    int          cnt = 0;
    logic        en_q = 0, hang = 0, sticky = 0;
    logic [7:0]  acc = 0;
    alu_sequencer_if bus ();
    alu_sequencer #(.DEPTH(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .alu(bus), .result(result), .result_valid(result_valid), .pc(pc),
        .busy(busy), .halted(halted), .error(error)
    );
    always #5 clk = ~clk;
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_INC:  return a + 8'd1;
            default: return b;
        endcase
    endfunction
    // ALU model: done rises three edges after it sees alu_en rise; sticky mode holds done high
    // until shortly before the next completion, hang mode never completes.
    always @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= 0;
            en_q <= 0;
            acc <= 0;
            bus.alu_done <= 0;
            bus.alu_results <= 0;
        end else begin
            en_q <= bus.alu_en;
            if (!sticky || cnt == LAT - 2) bus.alu_done <= 0;
            if (bus.alu_en && !en_q && !hang) cnt <= 1;
            else if (cnt != 0) begin
                if (cnt == LAT - 1) begin
                    bus.alu_done <= 1;
                    bus.alu_results <= alu_f(bus.alu_op, bus.alu_a, bus.alu_acc ? acc : bus.alu_b);
                    acc <= alu_f(bus.alu_op, bus.alu_a, bus.alu_acc ? acc : bus.alu_b);
                    cnt <= 0;
                end else cnt <= cnt + 1;
            end
        end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask
    task automatic prog(input int addr, input logic [21:0] d);
        prog_we = 1;
        prog_addr = addr[3:0];
        prog_data = d;
        @(posedge clk);
        #1 prog_we = 0;
    endtask
    task automatic run(input int budget, input bit disturb);
        int cyc;
        cyc = 0;
        res_q.delete();
        first_lat = -1;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        prog_we = 0;
        while (!halted && cyc < budget) begin
            if (disturb) begin
                start = 1;
                prog_we = 1;
                prog_addr = 0;
                prog_data = mk_instr(1, OP_NOP, 0, 0, 0);
            end
            @(posedge clk);
            #1 cyc++;
            start = 0;
            prog_we = 0;
            if (result_valid) begin
                res_q.push_back(result);
                if (first_lat < 0) first_lat = cyc;
            end
        end
        halt_cyc = cyc;
        chk("halt_reached", halted, 1);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_pc", pc, 0);
        chk("rst_alu_op", bus.alu_op, 4'hF);
        chk("rst_alu_ab", {bus.alu_a, bus.alu_b, bus.alu_acc}, 0);
        chk("rst_alu_en", bus.alu_en, 0);
        chk("rst_result", {result, result_valid}, 0);
        chk("rst_flags", {busy, halted, error}, 0);
        // add 5+3, then add acc(8)+2; sticky done checks that only a rising edge completes
        sticky = 1;
        prog(0, mk_instr(0, OP_ADD, 0, 8'd5, 8'd3));
        prog(1, mk_instr(0, OP_ADD, 1, 8'd2, 8'd0));
        prog(2, mk_instr(1, OP_NOP, 0, 0, 0));
        run(100, 0);
        chk("add_count", res_q.size(), 2);
        chk("add_r0", res_q[0], 8'h08);
        chk("add_r1", res_q[1], 8'h0A);
        chk("add_latency", first_lat, 6);
        chk("add_pc", pc, 2);
        chk("add_error", error, 0);
        sticky = 0;
        // hung ALU: TIMEOUT+1 WAIT cycles after FETCH and ISSUE, then HALT with error
        hang = 1;
        repeat (2) @(posedge clk);
        #1 prog(0, mk_instr(0, OP_ADD, 0, 8'd1, 8'd1));
        prog(1, mk_instr(1, OP_NOP, 0, 0, 0));
        run(100, 0);
        chk("to_error", error, 1);
        chk("to_count", res_q.size(), 0);
        chk("to_cycles", halt_cyc, 18);
        chk("to_result_kept", result, 8'h0A);
        chk("to_alu_en", bus.alu_en, 0);
        hang = 0;
        run(100, 0);
        chk("to_clear_error", error, 0);
        chk("to_restart_r0", res_q[0], 8'h02);
        // sub wraps negative; inc 0xFF written in the same cycle as start
        prog(0, mk_instr(0, OP_SUB, 0, 8'd3, 8'd5));
        run(100, 0);
        chk("sub_r0", res_q[0], 8'hFE);
        prog_we = 1;
        prog_addr = 0;
        prog_data = mk_instr(0, OP_INC, 0, 8'hFF, 8'h00);
        run(100, 0);
        chk("inc_count", res_q.size(), 1);
        chk("inc_r0", res_q[0], 8'h00);
        // reset in WAIT of the second instruction
        prog(0, mk_instr(0, OP_ADD, 0, 8'd1, 8'd2));
        prog(1, mk_instr(0, OP_ADD, 0, 8'd3, 8'd4));
        prog(2, mk_instr(1, OP_NOP, 0, 0, 0));
        begin
            int k, rv;
            k = 0;
            rv = 0;
            start = 1;
            @(posedge clk);
            #1 start = 0;
            while (!(pc == 1 && bus.alu_en) && k < 50) begin
                @(posedge clk);
                #1 k++;
            end
            chk("rst_reach_wait", k < 50, 1);
            @(posedge clk);
            #1 rst = 1;
            #1;
            chk("mid_rst_flags", {busy, halted, error, result_valid}, 0);
            chk("mid_rst_pc", pc, 0);
            chk("mid_rst_alu", {bus.alu_en, bus.alu_op, result}, {1'b0, 4'hF, 8'h00});
            @(posedge clk);
            #1 rst = 0;
            repeat (8) begin
                @(posedge clk);
                #1 rv += int'(result_valid);
            end
            chk("mid_rst_no_valid", rv, 0);
        end
        run(100, 0);
        chk("rerun_count", res_q.size(), 2);
        chk("rerun_r", {res_q[0], res_q[1]}, {8'h03, 8'h07});
        // 16 nops, no halt bit: stops at the last entry without wrapping
        for (int i = 0; i < 16; i++) prog(i, mk_instr(0, OP_NOP, 0, 8'h00, i[7:0]));
        run(400, 0);
        chk("nop_count", res_q.size(), 16);
        chk("nop_first_last", {res_q[0], res_q[15]}, {8'h00, 8'h0F});
        chk("nop_pc", pc, 15);
        // start/prog_we hammered while busy must be ignored
        prog(0, mk_instr(0, OP_ADD, 0, 8'd5, 8'd3));
        prog(1, mk_instr(0, OP_ADD, 1, 8'd2, 8'd0));
        prog(2, mk_instr(1, OP_NOP, 0, 0, 0));
        run(100, 1);
        chk("dist_count", res_q.size(), 2);
        chk("dist_r", {res_q[0], res_q[1]}, {8'h08, 8'h0A});
        run(100, 0);
        chk("dist_mem_kept", res_q.size(), 2);
        chk("dist_mem_r", {res_q[0], res_q[1]}, {8'h08, 8'h0A});
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning instruction-memory entries (power of two, 2..256).
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning max cycles to wait for alu_done per instruction.
REQ-003 SHALL have ports:
  clk  in  1  clock, all state on posedge
  rst  in  1  reset, asynchronous, active-high
  prog_we  in  1  write instruction memory (accepted only in IDLE/HALT)
  prog_addr  in  log2(DEPTH)  write address
  prog_data  in  22  {halt[21], op[20:17], acc[16], a[15:8], b[7:0]}
  start  in  1  begin execution at address 0
  alu_done  in  1  ALU completion flag
  alu_results  in  8  ALU result, valid when alu_done rises
  alu_a, alu_b  out  8  operands to ALU
  alu_op  out  4  opcode to ALU
  alu_acc  out  1  select ALU accumulator as B
  alu_en  out  1  issue strobe to ALU
  result  out  8  last retired result
  result_valid  out  1  one-cycle pulse per retired instruction
  pc  out  log2(DEPTH)  address of current instruction
  busy  out  1  high in FETCH/ISSUE/WAIT/RETIRE
  halted  out  1  high in HALT
  error  out  1  sticky timeout flag

Function
REQ-004 SHALL implement states IDLE, FETCH, ISSUE, WAIT, RETIRE, HALT.
REQ-005 IDLE: start=1 -> pc=0, FETCH; otherwise stay.
REQ-006 FETCH (1 cycle): read mem[pc] into instruction register; halt bit=1 -> HALT without issuing, else ISSUE.
REQ-007 ISSUE (1 cycle): drive alu_a/alu_b/alu_op/alu_acc from instruction register, alu_en=1, clear timeout counter, -> WAIT.
REQ-008 alu_a/alu_b/alu_op/alu_acc SHALL hold stable from ISSUE until leaving WAIT; alu_en SHALL stay high through WAIT.
REQ-009 WAIT: completion = rising edge of alu_done (alu_done=1 and previous-cycle alu_done=0); a level-high alu_done left over from a prior instruction SHALL NOT count.
REQ-010 On completion: capture alu_results into result, -> RETIRE.
REQ-011 RETIRE (1 cycle): result_valid=1, alu_en=0; pc==DEPTH-1 -> HALT (no wrap), else pc+1 -> FETCH.
REQ-012 WAIT timeout: counter reaches TIMEOUT without completion -> error=1, alu_en=0, HALT; result unchanged, no result_valid.
REQ-013 HALT: start=1 -> clear error, pc=0, FETCH; otherwise stay.
REQ-014 Opcode 4'b1111 (nop) SHALL be issued normally and its result retired like any other.
REQ-015 start while busy SHALL be ignored; prog_we while busy SHALL be ignored (memory unchanged).
REQ-016 prog_we and start in the same IDLE cycle: write completes; execution begins next cycle with updated contents visible to FETCH.
REQ-017 Minimum latency per instruction: FETCH + ISSUE + ALU latency + RETIRE; with the 4-cycle ALU, 6 cycles start-to-result_valid for the first instruction.

Reset
REQ-018 rst SHALL force IDLE, pc=0, alu_a/alu_b=0, alu_op=4'b1111, alu_acc=0, alu_en=0, result=0, result_valid=0, error=0, halted=0, busy=0, alu_done history=0.
REQ-019 rst mid-operation SHALL abort immediately; no result_valid pulse SHALL follow; instruction memory contents SHALL NOT be reset.

Structure
REQ-020 Opcode constants (shared with the ALU), instruction-field bit positions, and state encoding SHALL live in a shared package alu_pkg.
REQ-021 Instruction storage SHALL be a sub-module instr_mem (synchronous write, combinational read, DEPTH x 22).

Verification
REQ-022 Program {add a=5 b=3}, {add acc=1 a=2}, {halt}; start -> result_valid with result 8 then 10 (0x0A); halted=1, pc=2.
REQ-023 Program {sub a=3 b=5}, {halt} -> result 0xFE; {increment a=0xFF} -> result 0x00 (wrap).
REQ-024 ALU model never raises alu_done -> error=1 and halted=1 after TIMEOUT+1 WAIT cycles; no result_valid; restart start clears error.
REQ-025 Assert rst in WAIT of instruction 2 -> IDLE next edge, all outputs at reset values, no result_valid; restart re-executes from pc=0 with unchanged memory.
REQ-026 Fill all 16 entries with nop (no halt) -> 16 result_valid pulses, HALT at pc=15, no wrap to 0.
REQ-027 prog_we and start while busy -> memory and execution unaffected, results identical to undisturbed run.
